// File: rtl/apb_pkg.sv
// Shared types for the APB response checker: FSM encoding and counter widths.
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam int XFER_CNT_W = 16;
   localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/apb_bank_regfile.sv
// Banked storage for the APB checker: one write port, one combinational read port,
// every word returns to RESET_VAL on reset.
module apb_bank_regfile #(
   parameter int                    NUM_BANKS  = 2,
   parameter int                    DATA_WIDTH = 8,
   parameter int                    ADDR_WIDTH = 3,
   parameter int                    BANK_W     = 1,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL  = 'hF9
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_we,
   input  logic [BANK_W-1:0]     i_wbank,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [BANK_W-1:0]     i_rbank,
   input  logic [ADDR_WIDTH-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [NUM_BANKS][2**ADDR_WIDTH];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            for (int w = 0; w < 2**ADDR_WIDTH; w++) begin
               r_mem[b][w] <= RESET_VAL;
            end
         end
      end else if (i_we) begin
         r_mem[i_wbank][i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_rbank][i_raddr];

endmodule

// File: rtl/apb_resp_checker.sv
// APB slave that inserts WAIT_STATES wait cycles, answers from banked storage and
// flags protocol violations (sticky) while counting completed transfers.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no transfer; waits for a setup phase (psel set, penable low)
// ST_SETUP  | one cycle; bus fields are latched on the way to ST_ACCESS
// ST_ACCESS | wait counter runs down; pready at zero, then SETUP or IDLE
module apb_resp_checker
   import apb_pkg::*;
#(
   parameter int                    BANK_ADDR   = 2,
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ADDR_WIDTH  = 3,
   parameter int                    WAIT_STATES = 2,
   parameter logic [DATA_WIDTH-1:0] RESET_VAL   = 'hF9
) (
   input  logic                  m_pclk,
   input  logic                  m_presetn,
   input  logic [BANK_ADDR-1:0]  m_psel,
   input  logic                  m_penable,
   input  logic                  m_pwrite,
   input  logic [ADDR_WIDTH-1:0] m_paddr,
   input  logic [DATA_WIDTH-1:0] m_pwdata,
   output logic [DATA_WIDTH-1:0] m_prdata,
   output logic                  m_pready,
   output logic                  m_pslverr,
   output logic                  m_err_flag,
   output logic [XFER_CNT_W-1:0] m_xfer_cnt
);

   localparam int BANK_W = (BANK_ADDR > 1) ? $clog2(BANK_ADDR) : 1;

   apb_state_e            r_state;
   apb_state_e            w_state_nxt;
   logic [BANK_ADDR-1:0]  r_psel;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic                  r_pwrite;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic [WAIT_CNT_W-1:0] r_wait_cnt;
   logic                  r_err_flag;
   logic [XFER_CNT_W-1:0] r_xfer_cnt;

   logic                  w_onehot;
   logic [BANK_W-1:0]     w_bank;
   logic                  w_in_wait;
   logic                  w_ready;
   logic                  w_new_setup;
   logic                  w_mismatch;
   logic                  w_viol;
   logic                  w_we;
   logic [DATA_WIDTH-1:0] w_rdata;

   assign w_onehot = $onehot(r_psel);

   always_comb begin
      w_bank = '0;
      for (int i = 0; i < BANK_ADDR; i++) begin
         if (r_psel[i]) w_bank = BANK_W'(i);
      end
   end

   assign w_in_wait   = (r_state == ST_ACCESS) && (r_wait_cnt != '0);
   assign w_ready     = (r_state == ST_ACCESS) && (r_wait_cnt == '0);
   assign w_new_setup = (|m_psel) && !m_penable;
   assign w_mismatch  = (m_psel != r_psel) || (m_paddr != r_paddr) ||
                        (m_pwrite != r_pwrite) || (m_pwdata != r_pwdata);

   // The completion cycle doubles as the next transfer's setup phase, so the
   // bus is only held to the latched fields while pready is still low.
   assign w_viol = ((r_state == ST_IDLE) && (|m_psel) && m_penable) ||
                   (w_in_wait && (!m_penable || w_mismatch));

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (!w_viol && w_new_setup) w_state_nxt = ST_SETUP;
         end
         ST_SETUP: w_state_nxt = ST_ACCESS;
         ST_ACCESS: begin
            if (w_viol)       w_state_nxt = ST_IDLE;
            else if (w_ready) w_state_nxt = w_new_setup ? ST_SETUP : ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge m_pclk or negedge m_presetn) begin
      if (!m_presetn) r_state <= ST_IDLE;
      else            r_state <= w_state_nxt;
   end

   always_ff @(posedge m_pclk or negedge m_presetn) begin
      if (!m_presetn) begin
         r_psel     <= '0;
         r_paddr    <= '0;
         r_pwrite   <= 1'b0;
         r_pwdata   <= '0;
         r_wait_cnt <= '0;
         r_err_flag <= 1'b0;
         r_xfer_cnt <= '0;
      end else begin
         if (r_state == ST_SETUP) begin
            r_psel     <= m_psel;
            r_paddr    <= m_paddr;
            r_pwrite   <= m_pwrite;
            r_pwdata   <= m_pwdata;
            r_wait_cnt <= WAIT_CNT_W'(WAIT_STATES);
         end else if (w_in_wait) begin
            r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
         end
         if (w_viol)  r_err_flag <= 1'b1;
         if (w_ready) r_xfer_cnt <= r_xfer_cnt + XFER_CNT_W'(1);
      end
   end

   // A multi-bank select completes with an error and never touches storage.
   assign w_we = w_ready && r_pwrite && w_onehot;

   apb_bank_regfile #(
      .NUM_BANKS  (BANK_ADDR),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .BANK_W     (BANK_W),
      .RESET_VAL  (RESET_VAL)
   ) u_regfile (
      .i_clk   (m_pclk),
      .i_rst_n (m_presetn),
      .i_we    (w_we),
      .i_wbank (w_bank),
      .i_waddr (r_paddr),
      .i_wdata (r_pwdata),
      .i_rbank (w_bank),
      .i_raddr (r_paddr),
      .o_rdata (w_rdata)
   );

   assign m_pready   = w_ready;
   assign m_pslverr  = w_ready && !w_onehot;
   assign m_prdata   = (w_ready && !r_pwrite && w_onehot) ? w_rdata : '0;
   assign m_err_flag = r_err_flag;
   assign m_xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_apb_resp_checker.sv
// Directed bench for apb_resp_checker: one instance with two wait states, one with none.
module tb_apb_resp_checker;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        use0;
   logic [1:0]  tb_psel;
   logic        tb_penable;
   logic        tb_pwrite;
   logic [2:0]  tb_paddr;
   logic [7:0]  tb_pwdata;

   logic [1:0]  psel2, psel0;
   logic        pen2, pen0;
   logic [7:0]  prdata2, prdata0, prdata;
   logic        pready2, pready0, pready;
   logic        pslverr2, pslverr0, pslverr;
   logic        err2, err0, err_flag;
   logic [15:0] cnt2, cnt0, xfer_cnt;

   int   tests = 0;
   int   fails = 0;
   logic stray;

   always #5 clk = ~clk;

   assign psel2 = use0 ? 2'b00 : tb_psel;
   assign pen2  = use0 ? 1'b0  : tb_penable;
   assign psel0 = use0 ? tb_psel    : 2'b00;
   assign pen0  = use0 ? tb_penable : 1'b0;

   assign prdata   = use0 ? prdata0  : prdata2;
   assign pready   = use0 ? pready0  : pready2;
   assign pslverr  = use0 ? pslverr0 : pslverr2;
   assign err_flag = use0 ? err0     : err2;
   assign xfer_cnt = use0 ? cnt0     : cnt2;

   apb_resp_checker #(
      .BANK_ADDR(2), .DATA_WIDTH(8), .ADDR_WIDTH(3), .WAIT_STATES(2), .RESET_VAL(8'hF9)
   ) u_dut2 (
      .m_pclk(clk), .m_presetn(rst_n), .m_psel(psel2), .m_penable(pen2),
      .m_pwrite(tb_pwrite), .m_paddr(tb_paddr), .m_pwdata(tb_pwdata),
      .m_prdata(prdata2), .m_pready(pready2), .m_pslverr(pslverr2),
      .m_err_flag(err2), .m_xfer_cnt(cnt2)
   );

   apb_resp_checker #(
      .BANK_ADDR(2), .DATA_WIDTH(8), .ADDR_WIDTH(3), .WAIT_STATES(0), .RESET_VAL(8'hF9)
   ) u_dut0 (
      .m_pclk(clk), .m_presetn(rst_n), .m_psel(psel0), .m_penable(pen0),
      .m_pwrite(tb_pwrite), .m_paddr(tb_paddr), .m_pwdata(tb_pwdata),
      .m_prdata(prdata0), .m_pready(pready0), .m_pslverr(pslverr0),
      .m_err_flag(err0), .m_xfer_cnt(cnt0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle();
      tb_psel    = 2'b00;
      tb_penable = 1'b0;
      tb_pwrite  = 1'b0;
      tb_paddr   = 3'd0;
      tb_pwdata  = 8'h00;
   endtask

   // Full transfer from an idle bus; n_acc is the ACCESS cycle holding pready, -1 on timeout.
   task automatic xfer(input logic [1:0] sel, input logic [2:0] addr, input logic wr,
                       input logic [7:0] wd, output int n_acc, output logic [7:0] rd,
                       output logic se);
      tb_psel    = sel;
      tb_paddr   = addr;
      tb_pwrite  = wr;
      tb_pwdata  = wd;
      tb_penable = 1'b0;
      @(posedge clk); #1;
      tb_penable = 1'b1;
      if (pready !== 1'b0 || prdata !== 8'h00 || pslverr !== 1'b0) stray = 1'b1;
      @(posedge clk); #1;
      n_acc = -1;
      rd    = 8'h00;
      se    = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         if (pready === 1'b1) begin
            n_acc = i;
            rd    = prdata;
            se    = pslverr;
            break;
         end
         if (prdata !== 8'h00 || pslverr !== 1'b0) stray = 1'b1;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      bus_idle();
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int         n;
      logic [7:0] rd;
      logic       se;
      logic [5:0] pat;
      logic       seen;

      use0  = 1'b0;
      stray = 1'b0;
      bus_idle();

      #3 rst_n = 1'b0;
      #3;
      chk("rst_pready",  32'(pready),   32'h0);
      chk("rst_pslverr", 32'(pslverr),  32'h0);
      chk("rst_prdata",  32'(prdata),   32'h0);
      chk("rst_err",     32'(err_flag), 32'h0);
      chk("rst_cnt",     32'(xfer_cnt), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // write/read back bank0 addr5, pready on 3rd ACCESS cycle
      xfer(2'b01, 3'd5, 1'b1, 8'h3C, n, rd, se);
      chk("wr_wait_cycles", 32'(n), 32'd3);
      xfer(2'b01, 3'd5, 1'b0, 8'h00, n, rd, se);
      chk("rd_wait_cycles", 32'(n), 32'd3);
      chk("rd_data_3c",     32'(rd), 32'h3C);
      chk("rd_slverr",      32'(se), 32'h0);
      chk("cnt_after_2",    32'(xfer_cnt), 32'd2);

      xfer(2'b10, 3'd0, 1'b0, 8'h00, n, rd, se);
      chk("rd_b1_reset_val", 32'(rd), 32'hF9);
      chk("rd_b1_slverr",    32'(se), 32'h0);

      // multi-bank select: error response, no write, no read data
      xfer(2'b11, 3'd1, 1'b1, 8'hAA, n, rd, se);
      chk("multi_wr_wait", 32'(n),  32'd3);
      chk("multi_wr_err",  32'(se), 32'h1);
      xfer(2'b01, 3'd1, 1'b0, 8'h00, n, rd, se);
      chk("multi_b0_nowrite", 32'(rd), 32'hF9);
      xfer(2'b10, 3'd1, 1'b0, 8'h00, n, rd, se);
      chk("multi_b1_nowrite", 32'(rd), 32'hF9);
      xfer(2'b11, 3'd1, 1'b0, 8'h00, n, rd, se);
      chk("multi_rd_err",  32'(se), 32'h1);
      chk("multi_rd_zero", 32'(rd), 32'h0);
      chk("cnt_after_7",   32'(xfer_cnt), 32'd7);
      chk("no_stray_out",  32'(stray), 32'h0);

      // address change mid-ACCESS
      tb_psel = 2'b01; tb_paddr = 3'd1; tb_pwrite = 1'b1; tb_pwdata = 8'h77; tb_penable = 1'b0;
      @(posedge clk); #1;
      tb_penable = 1'b1;
      @(posedge clk); #1;
      chk("viol_pre_ready", 32'(pready), 32'h0);
      tb_paddr = 3'd2;
      @(posedge clk); #1;
      chk("viol_err_set", 32'(err_flag), 32'h1);
      bus_idle();
      seen = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (pready !== 1'b0) seen = 1'b1;
      end
      chk("viol_no_ready",  32'(seen),     32'h0);
      chk("viol_err_stick", 32'(err_flag), 32'h1);
      chk("viol_cnt_same",  32'(xfer_cnt), 32'd7);
      xfer(2'b01, 3'd1, 1'b0, 8'h00, n, rd, se);
      chk("viol_no_commit", 32'(rd), 32'hF9);

      // counter wrap from a preloaded value
      force u_dut2.r_xfer_cnt = 16'hFFFE;
      @(negedge clk);
      release u_dut2.r_xfer_cnt;
      @(posedge clk); #1;
      xfer(2'b10, 3'd7, 1'b1, 8'h5A, n, rd, se);
      chk("cnt_ffff", 32'(xfer_cnt), 32'hFFFF);
      xfer(2'b10, 3'd7, 1'b0, 8'h00, n, rd, se);
      chk("rd_b1_a7",  32'(rd), 32'h5A);
      chk("cnt_wrap0", 32'(xfer_cnt), 32'h0);
      xfer(2'b01, 3'd0, 1'b0, 8'h00, n, rd, se);
      chk("cnt_1", 32'(xfer_cnt), 32'd1);

      // reset during the pready cycle of a write
      tb_psel = 2'b10; tb_paddr = 3'd6; tb_pwrite = 1'b1; tb_pwdata = 8'hC3; tb_penable = 1'b0;
      @(posedge clk); #1;
      tb_penable = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("pre_rst_ready", 32'(pready), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_pready",  32'(pready),   32'h0);
      chk("arst_pslverr", 32'(pslverr),  32'h0);
      chk("arst_prdata",  32'(prdata),   32'h0);
      chk("arst_err",     32'(err_flag), 32'h0);
      chk("arst_cnt",     32'(xfer_cnt), 32'h0);
      bus_idle();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      xfer(2'b10, 3'd6, 1'b0, 8'h00, n, rd, se);
      chk("arst_no_commit", 32'(rd), 32'hF9);
      xfer(2'b10, 3'd7, 1'b0, 8'h00, n, rd, se);
      chk("arst_storage_reset", 32'(rd), 32'hF9);

      // back-to-back writes on the zero-wait instance
      use0 = 1'b1;
      bus_idle();
      @(posedge clk); #1;
      pat = 6'b0;
      tb_psel = 2'b01; tb_pwrite = 1'b1; tb_paddr = 3'd0; tb_pwdata = 8'h11; tb_penable = 1'b0;
      @(posedge clk); #1; pat = {pat[4:0], pready}; tb_penable = 1'b1;
      @(posedge clk); #1; pat = {pat[4:0], pready}; tb_paddr = 3'd1; tb_pwdata = 8'h22; tb_penable = 1'b0;
      @(posedge clk); #1; pat = {pat[4:0], pready}; tb_penable = 1'b1;
      @(posedge clk); #1; pat = {pat[4:0], pready}; tb_paddr = 3'd2; tb_pwdata = 8'h33; tb_penable = 1'b0;
      @(posedge clk); #1; pat = {pat[4:0], pready}; tb_penable = 1'b1;
      @(posedge clk); #1; pat = {pat[4:0], pready};
      @(posedge clk); #1; bus_idle();
      chk("b2b_pattern", 32'(pat),      32'h15);
      chk("b2b_cnt3",    32'(xfer_cnt), 32'd3);
      chk("b2b_no_err",  32'(err_flag), 32'h0);
      xfer(2'b01, 3'd1, 1'b0, 8'h00, n, rd, se);
      chk("ws0_first_cycle", 32'(n),  32'd1);
      chk("b2b_rd_a1",       32'(rd), 32'h22);
      xfer(2'b01, 3'd2, 1'b0, 8'h00, n, rd, se);
      chk("b2b_rd_a2",       32'(rd), 32'h33);
      chk("b2b_cnt5",        32'(xfer_cnt), 32'd5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/apb_resp_checker.md
APB_RESP_CHECKER -- requirements
Module: apb_resp_checker

Interface
REQ-001 SHALL have parameter BANK_ADDR, default 2, meaning number of banks (width of m_psel, one bit per bank).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning data bus width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 3, meaning word address width per bank (2**ADDR_WIDTH words).
REQ-004 SHALL have parameter WAIT_STATES, default 2, range 0..15, meaning pready-low cycles inserted in ACCESS.
REQ-005 SHALL have parameter RESET_VAL, default 'hF9, meaning reset contents of every storage word.
REQ-006 SHALL have port m_pclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port m_presetn, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port m_psel, input, BANK_ADDR bits: bank select.
REQ-009 SHALL have port m_penable, input, 1 bit: APB enable.
REQ-010 SHALL have port m_pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port m_paddr, input, ADDR_WIDTH bits: word address.
REQ-012 SHALL have port m_pwdata, input, DATA_WIDTH bits: write data.
REQ-013 SHALL have port m_prdata, output, DATA_WIDTH bits: read data.
REQ-014 SHALL have port m_pready, output, 1 bit: transfer completion.
REQ-015 SHALL have port m_pslverr, output, 1 bit: slave error, valid only while m_pready=1.
REQ-016 SHALL have port m_err_flag, output, 1 bit: sticky protocol-violation flag.
REQ-017 SHALL have port m_xfer_cnt, output, 16 bits: count of completed transfers.

Function
REQ-018 SHALL implement FSM states IDLE, SETUP, ACCESS; reset state IDLE.
REQ-019 IDLE->SETUP when |m_psel=1 and m_penable=0; all other IDLE inputs leave state unchanged.
REQ-020 SETUP->ACCESS on the next edge, latching psel, paddr, pwrite and pwdata; wait counter loads WAIT_STATES.
REQ-021 In ACCESS, m_pready SHALL be 0 while the wait counter is nonzero; the counter decrements once per cycle.
REQ-022 m_pready SHALL be 1 for exactly one cycle at counter zero; with WAIT_STATES=0 this is the first ACCESS cycle.
REQ-023 A write SHALL commit to storage[bank][paddr] on the m_pready=1 edge only.
REQ-024 m_prdata SHALL equal storage[bank][paddr] during the read m_pready=1 cycle, and 0 at all other times.
REQ-025 After the m_pready cycle: if |m_psel=1 and m_penable=0, go to SETUP (back-to-back, no IDLE cycle); else go to IDLE.
REQ-026 A non-one-hot m_psel latched in SETUP SHALL complete normally with m_pslverr=1, no storage write, and m_prdata=0.
REQ-027 m_pslverr SHALL be 0 whenever m_pready=0.
REQ-028 Protocol violations SHALL set m_err_flag and force IDLE at the next edge, with no commit and no count:
 - m_penable=1 while in IDLE with |m_psel=1;
 - m_penable=0 in ACCESS;
 - m_psel, m_paddr, m_pwrite or m_pwdata differing from the latched values in ACCESS.
REQ-029 m_err_flag SHALL be sticky and cleared only by reset.
REQ-030 m_xfer_cnt SHALL increment on every m_pready=1 edge, including pslverr transfers, and wrap 16'hFFFF->0.
REQ-031 Simultaneous pready completion and a new SETUP SHALL both take effect: commit, count, then SETUP.

Reset
REQ-032 On m_presetn=0, immediately and without a clock: state=IDLE, m_pready=0, m_pslverr=0, m_prdata=0, m_err_flag=0, m_xfer_cnt=0, storage=RESET_VAL.
REQ-033 Reset asserted mid-ACCESS SHALL abort the transfer with no commit.
REQ-034 Deassertion of reset SHALL take effect at the first following m_pclk edge.

Structure
REQ-035 The FSM state encodings and the 16-bit counter width SHALL live in shared package apb_pkg.
REQ-036 Storage SHALL be the sub-module apb_bank_regfile, with one write port, one combinational read port and reset to RESET_VAL.

Verification
REQ-037 Write 8'h3C to bank0 addr5, then read it back with WAIT_STATES=2 -> m_pready high in the 3rd ACCESS cycle; m_prdata=8'h3C; m_xfer_cnt=2.
REQ-038 Read bank1 addr0 with no prior write -> m_prdata=8'hF9, m_pslverr=0.
REQ-039 m_psel=2'b11 write 8'hAA to addr1 -> m_pready with m_pslverr=1; a subsequent read of both banks at addr1 returns 8'hF9.
REQ-040 m_paddr changes 1->2 mid-ACCESS -> m_err_flag=1, no m_pready, m_xfer_cnt unchanged, flag still 1 after 10 idle cycles.
REQ-041 Three back-to-back writes, no IDLE cycle, WAIT_STATES=0 -> a pready pulse every 2nd cycle; m_xfer_cnt=3.
REQ-042 Preload m_xfer_cnt to 16'hFFFF via transfers, then complete one more -> m_xfer_cnt=0; reset mid-ACCESS -> all outputs 0 immediately.
